// File: rtl/bcd_digit_formatter_pkg.sv
// Shared digit-code layout, error glyph and FSM state type for the seven-segment
// formatting path (digit code = {enable, dp, hex}).
package seven_segment_pkg;

    typedef logic [5:0] digit_code_t;

    localparam int          DIGIT_ENABLE_BIT = 5;
    localparam int          DIGIT_DP_BIT     = 4;
    localparam logic [3:0]  DIGIT_HEX_ERROR  = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } bcd_state_t;

    // 10**n as a 64-bit constant; used to size the overflow threshold at elaboration.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_formatter_shift_add3.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one
// bit, inserting the next binary MSB at the bottom.
module bcd_shift_add3 #(
    parameter int NUMBER_OF_DIGITS = 6
) (
    input  logic [4*NUMBER_OF_DIGITS-1:0] bcd_i,
    input  logic                          shift_in_i,
    output logic [4*NUMBER_OF_DIGITS-1:0] bcd_o
);

    logic [4*NUMBER_OF_DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        // The carry out of the top nibble is intentionally lost; overflow is handled upstream.
        bcd_o = (adj << 1) | {{(4*NUMBER_OF_DIGITS-1){1'b0}}, shift_in_i};
    end

endmodule

// File: rtl/bcd_digit_formatter.sv
// Iterative binary-to-BCD formatter producing {enable, dp, hex} codes per digit.
// Define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros; otherwise all digits are lit.
module bcd_digit_formatter
    import seven_segment_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS = 6,
    parameter int VALUE_WIDTH      = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        value_valid,
    output logic                        value_ready,
    input  logic [VALUE_WIDTH-1:0]      value,
    input  logic [NUMBER_OF_DIGITS-1:0] dp_select,
    output digit_code_t                 digits [0:NUMBER_OF_DIGITS-1],
    output logic                        overflow,
    output logic                        done
);

    localparam int          BCD_W     = 4 * NUMBER_OF_DIGITS;
    localparam int          CNT_W     = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
    localparam logic [63:0] OVF_LIMIT = pow10(NUMBER_OF_DIGITS);

    if (NUMBER_OF_DIGITS < 1 || NUMBER_OF_DIGITS > 8) begin : g_bad_digits
        $error("bcd_digit_formatter: NUMBER_OF_DIGITS must be in 1..8");
    end
    if (VALUE_WIDTH < 1 || VALUE_WIDTH > 27) begin : g_bad_width
        $error("bcd_digit_formatter: VALUE_WIDTH must be in 1..27");
    end

    bcd_state_t                  state_q;
    logic                        ready_q;
    logic                        done_q;
    logic                        overflow_q;
    digit_code_t                 digits_q [0:NUMBER_OF_DIGITS-1];

    logic [VALUE_WIDTH-1:0]      value_q;
    logic [NUMBER_OF_DIGITS-1:0] dp_q;
    logic                        ovf_pend_q;
    logic [BCD_W-1:0]            bcd_q;
    logic [CNT_W-1:0]            cnt_q;

    logic [BCD_W-1:0]            bcd_d;
    digit_code_t                 digits_d [0:NUMBER_OF_DIGITS-1];

    bcd_shift_add3 #(
        .NUMBER_OF_DIGITS(NUMBER_OF_DIGITS)
    ) u_shift_add3 (
        .bcd_i      (bcd_q),
        .shift_in_i (value_q[cnt_q]),
        .bcd_o      (bcd_d)
    );

    // Commit image, built from the finished accumulator and the latched dp mask.
    always_comb begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic lit_above;
        lit_above = 1'b0;
`endif
        for (int i = NUMBER_OF_DIGITS - 1; i >= 0; i--) begin
            digits_d[i] = '0;
            if (ovf_pend_q) begin
                digits_d[i][DIGIT_ENABLE_BIT] = 1'b1;
                digits_d[i][3:0]              = DIGIT_HEX_ERROR;
            end else begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
                // A digit stays lit if it or anything more significant is nonzero or dotted.
                lit_above = lit_above | (bcd_q[4*i +: 4] != 4'd0) | dp_q[i];
                digits_d[i][DIGIT_ENABLE_BIT] = lit_above | (i == 0);
`else
                digits_d[i][DIGIT_ENABLE_BIT] = 1'b1;
`endif
                digits_d[i][DIGIT_DP_BIT] = dp_q[i];
                digits_d[i][3:0]          = bcd_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (value_valid && ready_q) begin
                        value_q    <= value;
                        dp_q       <= dp_select;
                        ovf_pend_q <= (64'(value) >= OVF_LIMIT);
                        bcd_q      <= '0;
                        cnt_q      <= CNT_W'(VALUE_WIDTH - 1);
                        ready_q    <= 1'b0;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    if (cnt_q == '0) begin
                        state_q <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                COMMIT: begin
                    digits_q   <= digits_d;
                    overflow_q <= ovf_pend_q;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign value_ready = ready_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign digits      = digits_q;

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Scoreboard bench for bcd_digit_formatter: the driver queues hand-computed results,
// a negedge monitor checks each done pulse and the held outputs between commits.
module tb_bcd_digit_formatter;

    logic        clock = 1'b0;
    logic        reset;
    logic        value_valid;
    logic        value_ready;
    logic [19:0] value;
    logic [5:0]  dp_select;
    logic [5:0]  digits [0:5];
    logic        overflow;
    logic        done;

    bcd_digit_formatter #(
        .NUMBER_OF_DIGITS(6),
        .VALUE_WIDTH(20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .value       (value),
        .dp_select   (dp_select),
        .digits      (digits),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clock = ~clock;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [5:0] LZ = 6'b000000;
`else
    localparam logic [5:0] LZ = 6'b100000;
`endif
    localparam logic [5:0] E6 = 6'b101110;
    localparam logic [5:0] N9 = 6'b101001;

    typedef struct {
        logic [5:0][5:0] d;
        logic            ovf;
        int              due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic rst_at_edge = 1'b1;
    logic armed = 1'b0;
    logic [5:0][5:0] shown = '0;
    logic shown_ovf = 1'b0;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (!rst_at_edge) begin
            armed     = 1'b1;
            shown     = '0;
            shown_ovf = 1'b0;
            for (int i = 0; i < 6; i++) check($sformatf("rst_digit%0d", i), 64'(digits[i]), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
        end else if (armed) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 6; i++) check($sformatf("digit%0d", i), 64'(digits[i]), 64'(e.d[i]));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("latency", 64'(cyc), 64'(e.due));
                    check("ready_with_done", 64'(value_ready), 64'd1);
                    shown     = e.d;
                    shown_ovf = e.ovf;
                end
            end else begin
                for (int i = 0; i < 6; i++) check($sformatf("hold_digit%0d", i), 64'(digits[i]), 64'(shown[i]));
                check("hold_overflow", 64'(overflow), 64'(shown_ovf));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (value_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ready_timeout", 64'(value_ready), 64'd1);
    endtask

    // Called at a negedge; the transfer happens on the following rising edge.
    task automatic send(input logic [19:0] v, input logic [5:0] dp,
                        input logic [35:0] d, input logic ovf);
        exp_t e;
        wait_ready();
        value       = v;
        dp_select   = dp;
        value_valid = 1'b1;
        e.d   = d;
        e.ovf = ovf;
        e.due = cyc + 22;
        sb.push_back(e);
        @(negedge clock);
        value_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   d7;
        int   n;
        reset       = 1'b0;
        value_valid = 1'b0;
        value       = '0;
        dp_select   = '0;
        repeat (3) @(negedge clock);
        check("reset_ready", 64'(value_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(value_ready), 64'd1);

        send(20'd123456, 6'b000000,
             {6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110}, 1'b0);
        send(20'd42, 6'b000000, {LZ, LZ, LZ, LZ, 6'b100100, 6'b100010}, 1'b0);
        send(20'd5, 6'b000100, {LZ, LZ, LZ, 6'b110000, 6'b100000, 6'b100101}, 1'b0);
        send(20'd1000000, 6'b111111, {E6, E6, E6, E6, E6, E6}, 1'b1);
        send(20'd0, 6'b000000, {LZ, LZ, LZ, LZ, LZ, 6'b100000}, 1'b0);
        send(20'd1048575, 6'b000000, {E6, E6, E6, E6, E6, E6}, 1'b1);
        send(20'd0, 6'b100000,
             {6'b110000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000}, 1'b0);
        send(20'd999999, 6'b000000, {N9, N9, N9, N9, N9, N9}, 1'b0);

        // Valid held high: 7 accepted, 9 waits until the block is free again.
        wait_ready();
        value       = 20'd7;
        dp_select   = 6'b000000;
        value_valid = 1'b1;
        e.d   = {LZ, LZ, LZ, LZ, LZ, 6'b100111};
        e.ovf = 1'b0;
        e.due = cyc + 22;
        d7    = e.due;
        sb.push_back(e);
        @(negedge clock);
        value = 20'd9;
        repeat (10) @(negedge clock);
        check("busy_not_ready", 64'(value_ready), 64'd0);
        e.d   = {LZ, LZ, LZ, LZ, LZ, 6'b101001};
        e.due = d7 + 22;
        sb.push_back(e);
        while (cyc < d7) @(negedge clock);
        check("ready_at_done", 64'(value_ready), 64'd1);
        @(negedge clock);
        value_valid = 1'b0;

        // Reset asserted so that the 10th CONVERT edge sees it; nothing may commit.
        wait_ready();
        value       = 20'd123456;
        dp_select   = 6'b000011;
        value_valid = 1'b1;
        @(negedge clock);
        value_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready", 64'(value_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_ready_release", 64'(value_ready), 64'd1);
        repeat (25) @(negedge clock);
        send(20'd999999, 6'b000000, {N9, N9, N9, N9, N9, N9}, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_digit_formatter.md
# bcd_digit_formatter

Converts a binary value into the per-digit code array consumed by `seven_segment_with_dp`: a 6-bit code per digit, {enable, dp, hex}.
- Uses an iterative double-dabble (shift-add-3) engine.
- Optionally blanks leading zeros.
- Applies a latched decimal-point mask.
- Sits between application counters or measurements and the segment driver.
- Output registers hold the last committed result, so the display never shows partial conversions.

## Interface
- `NUMBER_OF_DIGITS`, 6: digits produced; legal range 1..8.
- `VALUE_WIDTH`, 20: binary input width; legal range 1..27.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-low.
- `value_valid` in 1: request; `value` and `dp_select` are sampled when it is accepted.
- `value_ready` out 1: block idle, can accept.
- `value` in `VALUE_WIDTH`: unsigned binary.
- `dp_select` in `NUMBER_OF_DIGITS`: one bit per digit; bit i lights the dp of digit i.
- `digits` out 6 × [0:`NUMBER_OF_DIGITS`-1]: per-digit code.
  - Bit 5 = enable, bit 4 = dp, [3:0] = hex.
  - `digits[0]` is the least significant (rightmost) digit.
- `overflow` out 1: the committed value exceeded 10^`NUMBER_OF_DIGITS`−1.
- `done` out 1: one-cycle pulse, new `digits` valid.

## Operation
- Handshake:
  - Transfer occurs on a rising edge with `value_valid && value_ready`.
  - `value_valid` may be held high; while `value_ready`=0 it is ignored, with no queueing.
- FSM:
  - IDLE: `value_ready`=1. On transfer, latch `value`, `dp_select` and the overflow compare (`value` ≥ 10^N), clear the BCD accumulator, load the bit counter with `VALUE_WIDTH`−1, go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, inserting the next binary MSB. Stay for exactly `VALUE_WIDTH` cycles, then go to COMMIT.
  - COMMIT: write the output registers, assert `done` next cycle, go to IDLE.
- BCD accumulator width: 4×`NUMBER_OF_DIGITS` bits.
  - Bits shifted out of the top are discarded.
  - The overflow path replaces the result.
- Commit, normal case: digit i gets hex = BCD nibble i, dp = `dp_select`[i], enable per blanking rule.
- Commit, overflow case: every digit gets hex=4'hE, enable=1, dp=0, and `overflow`=1.
- Without overflow, `overflow`=0.
- Blanking rule (macro enabled): digit i is enabled iff any of the following holds.
  - i=0.
  - Some digit j≥i has nonzero BCD.
  - Some `dp_select`[j], j≥i, is set.
- `value`=0 shows a single "0".

## Timing
- Reset values (while `reset`=0 on an edge):
  - `digits` all 6'b0 (blank).
  - `overflow`=0, `done`=0, `value_ready`=0.
  - FSM in IDLE; `value_ready`=1 from the first cycle after reset is released.
- Latency: transfer at edge E, CONVERT occupies edges E+1..E+`VALUE_WIDTH`, COMMIT writes at edge E+`VALUE_WIDTH`+1.
  - `digits`, `overflow` and `done`=1 are visible in that cycle.
  - 22 cycles for the defaults.
- `value_ready` is 1 again in the same cycle as `done`, so back-to-back throughput is one conversion per `VALUE_WIDTH`+2 cycles.
- `digits` and `overflow` are stable between commits.
- Reset mid-conversion aborts with no commit; outputs go to reset values.
- `dp_select` changes after transfer have no effect on the conversion in flight.

## Configuration
- `BCD_LEADING_ZERO_BLANK_EN` defined: blanking rule as above.
- Undefined: every digit's enable=1 on commit, so leading zeros are shown (e.g. 42 → "000042").
- Overflow and reset behaviour are identical either way.

## Structure
- Package `seven_segment_pkg`:
  - `typedef logic [5:0] digit_code_t`.
  - Constants `DIGIT_ENABLE_BIT`=5, `DIGIT_DP_BIT`=4, `DIGIT_HEX_ERROR`=4'hE.
  - FSM state enum `bcd_state_t` {IDLE, CONVERT, COMMIT}.
- Sub-module `bcd_shift_add3`: combinational, parameter `NUMBER_OF_DIGITS`; inputs BCD vector and one shift-in bit; output next BCD vector. One instance, used in CONVERT.
- Elaboration-time assertion on the parameter ranges.

## Test plan
All scenarios use defaults (N=6, W=20) with the macro defined unless noted.
- 123456, `dp_select`=0: `done` 22 cycles after transfer; hex digits[0..5]=6,5,4,3,2,1; all enabled; `overflow`=0.
- 42: digits[0]=6'b100010, digits[1]=6'b100100, digits[2..5]=0. With the macro undefined, digits[2..5]=6'b100000.
- 5, `dp_select`=6'b000100: digits[0]=6'b100101, [1]=6'b100000, [2]=6'b110000, [3..5]=0 (display "0.05").
- 1000000: `overflow`=1; all digits 6'b101110. Following 0: `overflow`=0; digits[0]=6'b100000, rest 0.
- `value_valid` held high with 7 then 9 presented: 7 accepted, 9 ignored until `value_ready`, then committed 22 cycles after its own transfer. `digits` show 7 unchanged in between.
- `reset`=0 during CONVERT cycle 10: no `done`; digits all 0; `value_ready`=1 the cycle after release; a new 999999 commits correctly.
